// File: rtl/sort_host.sv
// Host-side driver for an 8-entry, 8-bit in-place sorter: loads 8 beats, starts the sort,
// waits for completion (with timeout), then streams the sorted bytes back out with an order check.
module sort_host #(
    parameter int RD_LAT  = 2,
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       s_start,
    output logic       s_wr,
    output logic [2:0] s_addr,
    output logic [7:0] s_datain,
    input  logic [7:0] s_dataout,
    input  logic       s_ready,
    output logic       busy,
    output logic       order_err,
    output logic       timeout_err
);

    // Both streams: a beat transfers on a rising edge where valid && ready are both high.
    // A producer holds valid and data stable until that transfer; ready may depend on state only.
    typedef enum logic [2:0] {
        LOAD    = 3'd0,
        START   = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        READ    = 3'd4,
        SEND    = 3'd5
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] RD_LAST  = 3'(RD_LAT - 1);

    state_t     state, state_nxt;
    logic [2:0] cnt, idx, rcnt;
    logic [7:0] tcnt, prev;
    logic       hs_in, rd_done, hs_out, tmo, waiting;

    assign in_ready = (state == LOAD) && s_ready;
    assign busy     = (state != LOAD);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= LOAD;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hs_in     = 1'b0;
        rd_done   = 1'b0;
        hs_out    = 1'b0;
        tmo       = 1'b0;
        waiting   = 1'b0;
        case (state)
            LOAD: begin
                hs_in = in_valid && s_ready;
                if (hs_in && cnt == 3'd7) state_nxt = START;
            end
            START: state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (!s_ready)               state_nxt = WAIT_HI;
                else if (tcnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = LOAD;
                end else                    waiting = 1'b1;
            end
            WAIT_HI: begin
                if (s_ready)                state_nxt = READ;
                else if (tcnt == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = LOAD;
                end else                    waiting = 1'b1;
            end
            READ: begin
                if (rcnt == RD_LAST) begin
                    rd_done   = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (out_ready) begin
                    hs_out    = 1'b1;
                    state_nxt = (idx == 3'd7) ? LOAD : READ;
                end
            end
            default: state_nxt = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt         <= 3'd0;
            idx         <= 3'd0;
            rcnt        <= 3'd0;
            tcnt        <= 8'd0;
            prev        <= 8'd0;
            s_start     <= 1'b0;
            s_wr        <= 1'b0;
            s_addr      <= 3'd0;
            s_datain    <= 8'd0;
            out_valid   <= 1'b0;
            out_data    <= 8'd0;
            out_last    <= 1'b0;
            order_err   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            s_start <= (state == START);
            s_wr    <= hs_in;
            tcnt    <= waiting ? tcnt + 8'd1 : 8'd0;
            rcnt    <= (state == READ && !rd_done) ? rcnt + 3'd1 : 3'd0;

            if (hs_in) begin
                s_addr   <= cnt;
                s_datain <= in_data;
                cnt      <= cnt + 3'd1;
                if (cnt == 3'd0) begin
                    order_err   <= 1'b0;
                    timeout_err <= 1'b0;
                end
            end

            if (tmo) timeout_err <= 1'b1;

            // Address is set on entry to READ so it is already on the bus in the first READ cycle.
            if (state == WAIT_HI && s_ready) begin
                idx    <= 3'd0;
                s_addr <= 3'd0;
            end

            if (rd_done) begin
                out_data  <= s_dataout;
                out_valid <= 1'b1;
                out_last  <= (idx == 3'd7);
            end

            if (hs_out) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
                prev      <= out_data;
                if (idx != 3'd0 && out_data < prev) order_err <= 1'b1;
                if (idx != 3'd7) begin
                    idx    <= idx + 3'd1;
                    s_addr <= idx + 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sort_host.sv
// Directed bench for sort_host: behavioural sorter with selectable behaviour,
// expected-byte queue, and a single check task feeding the summary counts.
module tb_sort_host;

    localparam int RD_LAT  = 2;
    localparam int TIMEOUT = 255;

    typedef logic [7:0] arr_t [8];

    logic       clk, nrst;
    logic       in_valid, in_ready, out_valid, out_last, out_ready;
    logic [7:0] in_data, out_data, s_datain, s_dataout;
    logic       s_start, s_wr, busy, order_err, timeout_err;
    logic [2:0] s_addr;
    logic       s_ready = 1'b1;

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_q[$];
    logic       oe_hist[8];

    int         sorter_mode = 0;  // 0 sort, 1 fixed table, 2 never responds
    int         start_cnt   = 0;
    int         sort_cnt    = 0;
    arr_t       mem;
    logic [7:0] rd_q;
    arr_t       fix_tab = '{8'd1, 8'd2, 8'd3, 8'd9, 8'd4, 8'd5, 8'd6, 8'd7};

    sort_host #(.RD_LAT(RD_LAT), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .s_start(s_start), .s_wr(s_wr), .s_addr(s_addr), .s_datain(s_datain),
        .s_dataout(s_dataout), .s_ready(s_ready),
        .busy(busy), .order_err(order_err), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic arr_t sort8(input arr_t a);
        arr_t       b;
        logic [7:0] t;
        b = a;
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7 - i; j++)
                if (b[j] > b[j+1]) begin
                    t = b[j]; b[j] = b[j+1]; b[j+1] = t;
                end
        return b;
    endfunction

    // Behavioural sorter: one-register read path, busy for a few cycles after start.
    assign s_dataout = rd_q;
    always @(posedge clk) begin
        if (s_start) start_cnt <= start_cnt + 1;
        if (s_wr) mem[s_addr] <= s_datain;
        rd_q <= mem[s_addr];
        if (s_start) begin
            if (sorter_mode != 2) begin
                s_ready  <= 1'b0;
                sort_cnt <= 4;
            end
        end else if (!s_ready) begin
            if (sort_cnt == 0) begin
                s_ready <= 1'b1;
                if (sorter_mode == 1) mem <= fix_tab;
                else                  mem <= sort8(mem);
            end else sort_cnt <= sort_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input arr_t e);
        for (int i = 0; i < 8; i++) exp_q.push_back(e[i]);
    endtask

    task automatic load_frame(input arr_t v, input int gap);
        int   beat, cyc;
        logic acc;
        beat = 0; cyc = 0; acc = 1'b0;
        while (beat < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (acc && beat == 1) check("err_clr", {order_err, timeout_err}, 2'b00);
            in_valid = (gap == 0) || (cyc % 3 != 0);
            in_data  = v[beat];
            acc      = in_valid && in_ready;
            if (acc) beat++;
        end
        check("load_beats", beat, 8);
        @(negedge clk);
        in_valid = 1'b0;
        check("last_write", {busy, s_wr, s_addr, s_datain}, {1'b1, 1'b1, 3'd7, v[7]});
        @(negedge clk);
        check("start_pulse", {s_start, s_wr}, 2'b10);
    endtask

    task automatic read_frame(input int omode, input int abort_at, output logic aborted);
        int         n, cyc, last_hs, bad_in;
        logic       held, hs_prev;
        logic [7:0] held_d;
        n = 0; cyc = 0; last_hs = 0; bad_in = 0;
        held = 1'b0; hs_prev = 1'b0; held_d = 8'd0; aborted = 1'b0;
        while (n < 8 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (hs_prev) oe_hist[n-1] = order_err;
            hs_prev = 1'b0;
            if (n == abort_at) begin
                aborted = 1'b1;
                break;
            end
            if (held) check("stall_hold", {out_valid, out_data}, {1'b1, held_d});
            out_ready = (omode == 0) || (cyc % 3 == 0);
            if (omode != 0) begin
                in_valid = 1'b1;
                in_data  = 8'hee;
                if (in_ready) bad_in++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("exp_empty", 1, 0);
                else                   check("out_data", out_data, exp_q.pop_front());
                check("out_last", out_last, n == 7);
                if (omode == 0 && n > 0) check("byte_period", cyc - last_hs, RD_LAT + 1);
                last_hs = cyc;
                n++;
                hs_prev = 1'b1;
            end
            held   = out_valid && !out_ready;
            held_d = out_data;
        end
        in_valid = 1'b0;
        if (!aborted) begin
            check("frame_done", n, 8);
            if (n == 8) begin
                @(negedge clk);
                oe_hist[7] = order_err;
                check("busy_fall", busy, 0);
                check("in_ready_back", in_ready, 1);
            end
            if (omode != 0) check("ignore_in", bad_in, 0);
        end
    endtask

    initial begin
        arr_t v_a, exp_a, v_b, exp_b;
        int   s0;
        logic ab;
        v_a   = '{8'd7, 8'd3, 8'd5, 8'd0, 8'd6, 8'd1, 8'd4, 8'd2};
        exp_a = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7};
        v_b   = '{8'd200, 8'd17, 8'd99, 8'd17, 8'd255, 8'd0, 8'd128, 8'd64};
        exp_b = '{8'd0, 8'd17, 8'd17, 8'd64, 8'd99, 8'd128, 8'd200, 8'd255};

        nrst = 1'b0; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_outs", {out_valid, out_last, out_data, s_start, s_wr, s_addr, s_datain,
                             busy, order_err, timeout_err}, 0);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);
        nrst = 1'b1;

        // Full-rate load and readback
        s0 = start_cnt;
        push_exp(exp_a);
        load_frame(v_a, 0);
        read_frame(0, 8, ab);
        check("start_count", start_cnt - s0, 1);
        check("order_ok_full", order_err, 0);

        // Gapped input, throttled output, in_valid held high while busy
        s0 = start_cnt;
        push_exp(exp_a);
        load_frame(v_a, 1);
        read_frame(1, 8, ab);
        check("start_count_gap", start_cnt - s0, 1);
        check("order_ok_gap", order_err, 0);

        // Sorter returning an out-of-order sequence
        sorter_mode = 1;
        push_exp(fix_tab);
        load_frame(v_a, 0);
        read_frame(0, 8, ab);
        check("oe_before", oe_hist[3], 0);
        check("oe_set", oe_hist[4], 1);
        check("oe_sticky", order_err, 1);

        // Sorter never drops s_ready
        sorter_mode = 2;
        load_frame(v_a, 0);
        repeat (TIMEOUT - 1) @(negedge clk);
        check("tmo_wait", {busy, timeout_err}, 2'b10);
        @(negedge clk);
        check("tmo_fire", {busy, timeout_err, in_ready}, 3'b011);
        sorter_mode = 0;

        // Reset during READ of byte 3, then a fresh frame
        push_exp(exp_a);
        load_frame(v_a, 0);
        read_frame(0, 3, ab);
        check("abort_reached", ab, 1);
        nrst = 1'b0;
        #1;
        check("rst_mid", {out_valid, out_last, out_data, s_start, s_wr, s_addr, s_datain,
                          busy, order_err, timeout_err}, 0);
        check("rst_in_ready", in_ready, 1);
        @(negedge clk);
        nrst = 1'b1;
        exp_q.delete();
        push_exp(exp_b);
        load_frame(v_b, 1);
        read_frame(0, 8, ab);
        check("order_ok_dup", order_err, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
